// File: rtl/reg_ctx_stack_pkg.sv
// Shared definitions for the register-file context stack: operation encoding
// and the width helpers used by the top level, the storage and the interface.
package reg_ctx_stack_pkg;

    // Built as {push, pop}; push together with pop is a replace of the top entry.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    // Level must represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_ctx_stack_if.sv
// Bus between the CPU/control side (master) and the context stack (slave).
interface reg_ctx_stack_if
    import reg_ctx_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 9,
    parameter int DEPTH = 4
);
    localparam int LVLW = lvl_width(DEPTH);

    // push/pop/err_clr are single-cycle commands with no ready: the stack accepts
    // one operation on every rising edge; illegal ones set the sticky ovf/udf instead.
    logic                   push;
    logic                   pop;
    logic                   err_clr;
    logic [NREGS*WIDTH-1:0] reg_data;
    logic [NREGS*WIDTH-1:0] top_data;
    logic [LVLW-1:0]        level;
    logic                   empty;
    logic                   full;
    logic                   ovf;
    logic                   udf;

    modport master (
        output push, pop, err_clr, reg_data,
        input  top_data, level, empty, full, ovf, udf
    );

    modport slave (
        input  push, pop, err_clr, reg_data,
        output top_data, level, empty, full, ovf, udf
    );

endinterface

// File: rtl/reg_ctx_stack_mem.sv
// Snapshot storage: one write port, combinational reads of the top entry and
// the entry below it, both addressed from the current level.
module ctx_stack_mem
    import reg_ctx_stack_pkg::*;
#(
    parameter int DW    = 72,
    parameter int DEPTH = 4,
    parameter int LVLW  = lvl_width(DEPTH),
    parameter int IDXW  = idx_width(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [DW-1:0]   wr_data,
    input  logic [LVLW-1:0] level,
    output logic [DW-1:0]   rd_top,
    output logic [DW-1:0]   rd_below
);
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic [IDXW-1:0] top_idx;
    logic [IDXW-1:0] below_idx;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = wr_data;
    end

    // Contents are not reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        top_idx   = IDXW'(level - LVLW'(1));
        below_idx = IDXW'(level - LVLW'(2));
        rd_top    = (level >= LVLW'(1)) ? mem_q[top_idx]   : '0;
        rd_below  = (level >= LVLW'(2)) ? mem_q[below_idx] : '0;
    end

endmodule

// File: rtl/reg_ctx_stack.sv
// LIFO of register-file snapshots for CALL/RET and interrupt context save,
// with a registered top-of-stack bus, occupancy and sticky error flags.
module reg_ctx_stack
    import reg_ctx_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 9,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_ctx_stack_if.slave bus
);
    localparam int DW   = NREGS * WIDTH;
    localparam int LVLW = lvl_width(DEPTH);
    localparam int IDXW = idx_width(DEPTH);

    op_e             op;
    logic [LVLW-1:0] level_q, level_d;
    logic [DW-1:0]   top_data_q, top_data_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            ovf_set, udf_set;
    logic            empty, full;
    logic            wr_en;
    logic [IDXW-1:0] wr_idx;
    logic [DW-1:0]   rd_top, rd_below;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVLW'(DEPTH));

    ctx_stack_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LVLW  (LVLW),
        .IDXW  (IDXW)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (bus.reg_data),
        .level    (level_q),
        .rd_top   (rd_top),
        .rd_below (rd_below)
    );

    always_comb begin
        op         = op_e'({bus.push, bus.pop});
        level_d    = level_q;
        top_data_d = rd_top;   // already equals top_data_q; zero when empty
        wr_en      = 1'b0;
        wr_idx     = IDXW'(level_q);
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    level_d    = level_q + LVLW'(1);
                    top_data_d = bus.reg_data;
                end
            end
            OP_POP: begin
                if (empty) begin
                    udf_set = 1'b1;
                end else if (level_q == LVLW'(1)) begin
                    level_d    = '0;
                    top_data_d = '0;
                end else begin
                    level_d    = level_q - LVLW'(1);
                    top_data_d = rd_below;
                end
            end
            OP_REPL: begin
                // Replace on an empty stack degrades to a plain push, never an error.
                wr_en      = 1'b1;
                top_data_d = bus.reg_data;
                if (empty) begin
                    level_d = LVLW'(1);
                end else begin
                    wr_idx = IDXW'(level_q - LVLW'(1));
                end
            end
            default: ;
        endcase
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
        udf_d = (udf_q & ~bus.err_clr) | udf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            top_data_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            level_q    <= level_d;
            top_data_q <= top_data_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign bus.top_data = top_data_q;
    assign bus.level    = level_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;

endmodule

// File: tb/tb_reg_ctx_stack.sv
// Directed, table-driven bench for reg_ctx_stack (WIDTH=8, NREGS=9, DEPTH=4).
module tb_reg_ctx_stack;

    localparam int WIDTH = 8;
    localparam int NREGS = 9;
    localparam int DEPTH = 4;
    localparam int DW    = WIDTH * NREGS;

    localparam logic [DW-1:0] S1  = {8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [DW-1:0] S2  = {8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h12};
    localparam logic [DW-1:0] S3  = {9{8'h77}};
    localparam logic [DW-1:0] S4  = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    localparam logic [DW-1:0] SA  = {9{8'hAA}};
    localparam logic [DW-1:0] S5  = {9{8'h55}};
    localparam logic [DW-1:0] S33 = {9{8'h33}};
    localparam logic [DW-1:0] RND = '1;  // marker: drive random data, must be ignored

    logic clk;
    logic rst_n;

    reg_ctx_stack_if #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) bus ();

    reg_ctx_stack #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          push;
        logic          pop;
        logic          clr;
        logic [DW-1:0] data;
        logic [DW-1:0] e_top;
        int            e_lvl;
        logic          e_empty;
        logic          e_full;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [DW-1:0] top, input int lvl,
                             input logic emp, input logic ful, input logic ovf, input logic udf);
        chk({tag, ".top_data"}, bus.top_data, top);
        chk({tag, ".level"},    DW'(bus.level), DW'(lvl));
        chk({tag, ".empty"},    DW'(bus.empty), DW'(emp));
        chk({tag, ".full"},     DW'(bus.full),  DW'(ful));
        chk({tag, ".ovf"},      DW'(bus.ovf),   DW'(ovf));
        chk({tag, ".udf"},      DW'(bus.udf),   DW'(udf));
    endtask

    task automatic rand_data(output logic [DW-1:0] d);
        for (int i = 0; i < NREGS; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
    endtask

    // driver: inputs change on the falling edge, outputs checked 1ns after the rising edge
    task automatic drive(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
        logic [DW-1:0] dd;
        @(negedge clk);
        if (d === RND) rand_data(dd); else dd = d;
        bus.push     = p;
        bus.pop      = q;
        bus.err_clr  = c;
        bus.reg_data = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic p, input logic q, input logic c, input logic [DW-1:0] d,
                       input logic [DW-1:0] t, input int l, input logic em, input logic fu,
                       input logic ov, input logic ud);
        vec_t v;
        v.push = p; v.pop = q; v.clr = c; v.data = d;
        v.e_top = t; v.e_lvl = l; v.e_empty = em; v.e_full = fu; v.e_ovf = ov; v.e_udf = ud;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.err_clr  = 1'b0;
        bus.reg_data = '0;

        //         push pop clr data  top  lvl emp full ovf udf
        // fill and overflow
        add(1, 0, 0, S1,  S1,  1, 0, 0, 0, 0);
        add(1, 0, 0, S2,  S2,  2, 0, 0, 0, 0);
        add(1, 0, 0, S3,  S3,  3, 0, 0, 0, 0);
        add(1, 0, 0, S4,  S4,  4, 0, 1, 0, 0);
        add(1, 0, 0, SA,  S4,  4, 0, 1, 1, 0);
        // drain and underflow
        add(0, 1, 0, RND, S3,  3, 0, 0, 1, 0);
        add(0, 1, 0, RND, S2,  2, 0, 0, 1, 0);
        add(0, 1, 0, RND, S1,  1, 0, 0, 1, 0);
        add(0, 1, 0, RND, '0,  0, 1, 0, 1, 0);
        add(0, 1, 0, RND, '0,  0, 1, 0, 1, 1);
        add(0, 0, 1, RND, '0,  0, 1, 0, 0, 0);
        // replace, then simultaneous on empty
        add(1, 0, 0, S1,  S1,  1, 0, 0, 0, 0);
        add(1, 1, 0, S5,  S5,  1, 0, 0, 0, 0);
        add(0, 1, 0, RND, '0,  0, 1, 0, 0, 0);
        add(1, 1, 0, S33, S33, 1, 0, 0, 0, 0);
        add(0, 1, 0, RND, '0,  0, 1, 0, 0, 0);
        // error clear vs. set priority, replace while full, push-then-pop
        add(1, 0, 0, S1,  S1,  1, 0, 0, 0, 0);
        add(1, 0, 0, S2,  S2,  2, 0, 0, 0, 0);
        add(1, 0, 0, S3,  S3,  3, 0, 0, 0, 0);
        add(1, 0, 0, S4,  S4,  4, 0, 1, 0, 0);
        add(1, 0, 0, SA,  S4,  4, 0, 1, 1, 0);
        add(0, 0, 1, RND, S4,  4, 0, 1, 0, 0);
        add(1, 0, 1, SA,  S4,  4, 0, 1, 1, 0);
        add(1, 1, 0, S5,  S5,  4, 0, 1, 1, 0);
        add(0, 1, 0, RND, S3,  3, 0, 0, 1, 0);
        add(1, 0, 0, SA,  SA,  4, 0, 1, 1, 0);
        add(0, 1, 0, RND, S3,  3, 0, 0, 1, 0);
        add(0, 0, 0, RND, S3,  3, 0, 0, 1, 0);
        add(0, 1, 0, RND, S2,  2, 0, 0, 1, 0);
        add(0, 1, 0, RND, S1,  1, 0, 0, 1, 0);
        add(0, 1, 0, RND, '0,  0, 1, 0, 1, 0);
        add(0, 1, 1, RND, '0,  0, 1, 0, 0, 1);

        // reset held from time 0: outputs at reset values before any clock edge
        #3;
        chk_state("reset0", '0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, RND);
        drive(0, 0, 0, RND);
        chk_state("idle", '0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
            chk_state($sformatf("vec%0d", i), vecs[i].e_top, vecs[i].e_lvl,
                      vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_udf);
        end

        // asynchronous reset in the middle of a sequence
        drive(1, 0, 0, S1);
        drive(1, 0, 0, S2);
        drive(0, 1, 0, RND);
        drive(0, 1, 0, RND);
        drive(0, 1, 0, RND);  // underflow, udf=1
        drive(1, 0, 0, S4);
        chk_state("pre_rst", S4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.push = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", '0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, RND);
        drive(0, 0, 0, RND);
        chk_state("post_rst_idle", '0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1, 0, 0, S33);
        chk_state("post_rst_push", S33, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish before 50000ns");
        $fatal(1);
    end

endmodule

// File: doc/reg_ctx_stack.md
# reg_ctx_stack

Parametrised register-file context stack: on a push it snapshots all NREGS architectural registers into a LIFO entry. The top entry is always presented on a registered output bus for restore. It generalises the fixed 9×8 register stack with configurable width, register count and depth, explicit push/pop/replace operations, occupancy reporting and sticky overflow/underflow errors. It sits between the CPU register file and the control unit, serving CALL/RET and interrupt context save/restore.

## Interface
- WIDTH, 8: bits per register.
- NREGS, 9: registers captured per entry.
- DEPTH, 4: stack entries, ≥2.
- LVLW, $clog2(DEPTH+1): width of level output (derived, not overridden).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  1  save reg_data as new top.
- pop  in  1  discard top entry.
- err_clr  in  1  clear sticky ovf/udf.
- reg_data  in  NREGS*WIDTH  packed register snapshot, reg i at [i*WIDTH +: WIDTH].
- top_data  out  NREGS*WIDTH  registered copy of current top entry, zero when empty.
- level  out  LVLW  number of valid entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- ovf  out  1  sticky: push attempted while full.
- udf  out  1  sticky: pop attempted while empty.

## Operation
- Reset (rst_n low, asynchronous): level=0, top_data=0, empty=1, full=0, ovf=0, udf=0. Storage contents are don't-care and are not cleared.
- Operation decode, sampled each rising edge:
  - push only, not full: mem[level] ← reg_data; level+1; top_data ← reg_data.
  - push only, full: no state change; ovf ← 1.
  - pop only, level≥2: level−1; top_data ← mem[level−2].
  - pop only, level==1: level ← 0; top_data ← 0.
  - pop only, empty: no state change; udf ← 1.
  - push and pop, not empty (replace): mem[level−1] ← reg_data; top_data ← reg_data; level unchanged. Replace while full is legal and does not set ovf.
  - push and pop, empty: behaves as push; udf not set.
  - neither: hold.
- err_clr clears ovf/udf on the edge. If an error event coincides with err_clr, the set wins.
- The flags empty, full and level are derived from the registered level and are glitch-free.
- The stack never wraps. Pointer arithmetic saturates at 0 and DEPTH.

## Timing
- Zero-wait operation: one operation per clock, every clock.
- Latency 1: top_data, level, flags and errors are valid after the rising edge that samples the request.
- Push followed by pop on consecutive cycles: pop returns the entry below the one just pushed, with no bubble.
- reg_data is sampled only at the edge where push is high. It may change freely otherwise.
- Reset asserted mid-sequence: outputs go to reset values immediately, without waiting for clk. The first operation after deassertion is taken at the next rising edge following the release of rst_n.

## Structure
- Shared package/header reg_ctx_stack_pkg holds:
  - operation encoding constants OP_NONE, OP_PUSH, OP_POP, OP_REPL, built from {push,pop};
  - the LVLW derivation function.
- Sub-module ctx_stack_mem:
  - DEPTH×(NREGS*WIDTH) storage with a single write port (wr_en, wr_idx, wr_data);
  - two combinational read ports: top at idx level−1, below at idx level−2.
- Top level holds the level counter, the decode, the top_data register and the error flags.

## Test plan
Bench uses WIDTH=8, NREGS=9, DEPTH=4.
- Reset: drive rst_n low mid-clock → all outputs zero and empty=1 without a clock edge; release, idle 2 cycles → unchanged.
- Fill: push snapshots 11..99, 12..87, 77×9, 01..09 → level 1..4, top_data equals each pushed snapshot after 1 cycle, full=1 after the 4th push; 5th push of AA×9 → ovf=1, level=4, top_data still 01..09.
- Drain: 4 pops → top_data sequence 77×9, 12..87, 11..99, 0 with level 3..0; 5th pop → udf=1, empty=1, level=0.
- Replace: push 11..99, then push+pop with 55×9 → level=1, top_data=55×9; pop → empty, top_data=0.
- Simultaneous on empty: push+pop with 33×9 at level 0 → level=1, udf=0.
- Errors: set ovf, then assert err_clr alone → ovf=0. Assert err_clr together with an overflowing push → ovf stays 1.
